// File: rtl/rx_lane_align.sv
// Receive byte-lane aligner: locates the K28.5 lane, qualifies it and rotates the GT word stream so commas sit in byte 0.
// Optional RX_LANE_ALIGN_STAT_EN adds relock counter and offset visibility ports.
module rx_lane_align #(
    parameter logic [7:0]  P_COMMA    = 8'hBC,
    parameter int unsigned P_LOCK_CNT = 4,
    parameter int unsigned P_LOSS_CNT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_gt_bytealign,
    input  logic [31:0] i_gt_rx_data,
    input  logic [3:0]  i_gt_rx_charisk,
    output logic [31:0] o_rx_data,
    output logic [3:0]  o_rx_charisk,
`ifdef RX_LANE_ALIGN_STAT_EN
    output logic [15:0] o_relock_cnt,
    output logic [1:0]  o_offset,
`endif
    output logic        o_rx_aligned
);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_off, w_off_nx;
    logic [1:0]  r_cand, w_cand_nx;
    logic [3:0]  r_cnt, w_cnt_nx;
    logic [3:0]  w_cnt_inc;

    logic [31:0] r_cur, r_prev;
    logic [3:0]  r_cur_k, r_prev_k;

    logic [3:0]  w_hit;
    logic        w_valid;
    logic [1:0]  w_lane;

    logic [31:0] w_rot;
    logic [3:0]  w_rot_k;
    logic        w_aligned_nx;
    logic [3:0]  w_charisk_nx;

    always_comb begin
        w_hit = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            w_hit[n] = (i_gt_rx_data[8*n +: 8] == P_COMMA) && i_gt_rx_charisk[n];
        end
    end

    // Only single-hit words count as commas; zero or multiple hits are ignored.
    always_comb begin
        w_valid = 1'b1;
        w_lane  = 2'd0;
        case (w_hit)
            4'b0001: w_lane = 2'd0;
            4'b0010: w_lane = 2'd1;
            4'b0100: w_lane = 2'd2;
            4'b1000: w_lane = 2'd3;
            default: w_valid = 1'b0;
        endcase
    end

    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_HUNT;
            r_off   <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_off   <= w_off_nx;
            r_cand  <= w_cand_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_off_nx   = r_off;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        if (!i_gt_bytealign) begin
            w_state_nx = ST_HUNT;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_valid) begin
                        w_cand_nx = w_lane;
                        if (P_LOCK_CNT == 1) begin
                            w_state_nx = ST_LOCK;
                            w_off_nx   = w_lane;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = ST_CHECK;
                            w_cnt_nx   = 4'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_valid) begin
                        if (w_lane == r_cand) begin
                            if (w_cnt_inc == 4'(P_LOCK_CNT)) begin
                                w_state_nx = ST_LOCK;
                                w_off_nx   = r_cand;
                                w_cnt_nx   = '0;
                            end else begin
                                w_cnt_nx   = w_cnt_inc;
                            end
                        end else begin
                            w_state_nx = ST_HUNT;
                            w_cnt_nx   = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_valid) begin
                        if (w_lane == r_off) begin
                            w_cnt_nx = '0;
                        end else if (w_cnt_inc == 4'(P_LOSS_CNT)) begin
                            w_state_nx = ST_HUNT;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx   = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_HUNT;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // Rotation uses the next offset so the first locked output word is already aligned.
    always_comb begin
        w_rot        = 32'({r_cur, r_prev} >> (8 * w_off_nx));
        w_rot_k      = 4'({r_cur_k, r_prev_k} >> w_off_nx);
        w_aligned_nx = (w_state_nx == ST_LOCK);
        w_charisk_nx = w_aligned_nx ? w_rot_k : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur        <= '0;
            r_cur_k      <= '0;
            r_prev       <= '0;
            r_prev_k     <= '0;
            o_rx_data    <= '0;
            o_rx_charisk <= '0;
            o_rx_aligned <= 1'b0;
        end else begin
            r_cur        <= i_gt_rx_data;
            r_cur_k      <= i_gt_rx_charisk;
            r_prev       <= r_cur;
            r_prev_k     <= r_cur_k;
            o_rx_data    <= w_rot;
            o_rx_charisk <= w_charisk_nx;
            o_rx_aligned <= w_aligned_nx;
        end
    end

`ifdef RX_LANE_ALIGN_STAT_EN
    logic [15:0] r_relock_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_relock_cnt <= '0;
        end else if ((r_state == ST_LOCK) && (w_state_nx == ST_HUNT) && (r_relock_cnt != '1)) begin
            r_relock_cnt <= r_relock_cnt + 16'd1;
        end
    end

    assign o_relock_cnt = r_relock_cnt;
    assign o_offset     = r_off;
`endif

endmodule

// File: tb/tb_rx_lane_align.sv
// Directed bench for rx_lane_align: vector table for the lane-0 stream plus hand-written lock/loss/reset sequences.
module tb_rx_lane_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ba  = 1'b0;
    logic [31:0] din = '0;
    logic [3:0]  kin = '0;
    logic [31:0] o_data;
    logic [3:0]  o_k;
    logic        o_al;
`ifdef RX_LANE_ALIGN_STAT_EN
    logic [15:0] o_relock;
    logic [1:0]  o_off;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rx_lane_align #(.P_COMMA(8'hBC), .P_LOCK_CNT(4), .P_LOSS_CNT(3)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_gt_bytealign  (ba),
        .i_gt_rx_data    (din),
        .i_gt_rx_charisk (kin),
        .o_rx_data       (o_data),
        .o_rx_charisk    (o_k),
`ifdef RX_LANE_ALIGN_STAT_EN
        .o_relock_cnt    (o_relock),
        .o_offset        (o_off),
`endif
        .o_rx_aligned    (o_al)
    );

    localparam logic [31:0] C_L0 = 32'h000000BC;
    localparam logic [31:0] C_L1 = 32'h5500BC00;
    localparam logic [31:0] C_L2 = 32'h11BC2233;
    localparam logic [31:0] C_L3 = 32'hBC000077;

    typedef struct {
        logic        ba;
        logic [31:0] d;
        logic [3:0]  k;
        logic        exp_al;
        logic [31:0] exp_d;
        logic [3:0]  exp_k;
    } vec_t;

    vec_t tbl[14];
    logic [31:0] wb[41];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, return 1 time unit after the rising edge that samples it.
    task automatic step(input logic b, input logic [31:0] d, input logic [3:0] k);
        @(negedge clk);
        ba  = b;
        din = d;
        kin = k;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        rst = 1'b0;
    endtask

    initial begin
        // Lane-0 table: commas on even words, lock after the 4th (word 6), output = input delayed 2.
        for (int i = 0; i < 14; i++) begin
            tbl[i].ba = 1'b1;
            if (i % 2 == 0) begin
                tbl[i].d = {8'(i), 8'(i + 1), 8'(i + 2), 8'hBC};
                tbl[i].k = 4'b0001;
            end else begin
                tbl[i].d = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
                tbl[i].k = 4'b0000;
            end
        end
        for (int i = 0; i < 14; i++) begin
            tbl[i].exp_al = (i >= 6);
            tbl[i].exp_d  = (i >= 2) ? tbl[i-2].d : 32'h0;
            tbl[i].exp_k  = (i >= 6) ? tbl[i-2].k : 4'h0;
        end

        do_reset();
        chk("reset_aligned", {31'h0, o_al}, 32'h0);
        chk("reset_data", o_data, 32'h0);
        chk("reset_charisk", {28'h0, o_k}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].ba, tbl[i].d, tbl[i].k);
            chk($sformatf("tbl%0d_aligned", i), {31'h0, o_al}, {31'h0, tbl[i].exp_al});
            chk($sformatf("tbl%0d_data", i), o_data, tbl[i].exp_d);
            chk($sformatf("tbl%0d_charisk", i), {28'h0, o_k}, {28'h0, tbl[i].exp_k});
        end

        // Lane-2 commas every 8 words: lock on the 4th (word 24) at offset 2.
        do_reset();
        for (int s = 0; s <= 40; s++) begin
            wb[s] = (s % 8 == 0) ? C_L2 : (32'hCAFE0000 | 32'(s));
        end
        for (int s = 0; s <= 35; s++) begin
            step(1'b1, wb[s], (s % 8 == 0) ? 4'b0100 : 4'b0000);
            if (s == 23) chk("l2_pre_lock", {31'h0, o_al}, 32'h0);
            if (s == 24) chk("l2_lock", {31'h0, o_al}, 32'h1);
            if (s == 26) begin
                chk("l2_data", o_data, {wb[25][15:0], wb[24][31:16]});
                chk("l2_byte0", {24'h0, o_data[7:0]}, 32'hBC);
                chk("l2_charisk", {28'h0, o_k}, 32'h1);
            end
            if (s == 27) chk("l2_noncomma_k", {28'h0, o_k}, 32'h0);
            if (s == 34) begin
                chk("l2_byte0_b", {24'h0, o_data[7:0]}, 32'hBC);
                chk("l2_charisk_b", {28'h0, o_k}, 32'h1);
            end
        end

        // Lock at offset 1, lose it with 3 lane-3 commas, relock at offset 3.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, C_L1, 4'b0010);
        chk("c_lock_l1", {31'h0, o_al}, 32'h1);
        step(1'b1, C_L3, 4'b1000);
        step(1'b1, C_L3, 4'b1000);
        chk("c_loss2_still", {31'h0, o_al}, 32'h1);
        step(1'b1, C_L3, 4'b1000);
        chk("c_loss3_drop", {31'h0, o_al}, 32'h0);
        chk("c_loss3_k", {28'h0, o_k}, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, C_L3, 4'b1000);
        chk("c_relock_pre", {31'h0, o_al}, 32'h0);
        step(1'b1, C_L3, 4'b1000);
        chk("c_relock", {31'h0, o_al}, 32'h1);
        step(1'b1, C_L3, 4'b1000);
        step(1'b1, C_L3, 4'b1000);
        chk("c_l3_byte0", {24'h0, o_data[7:0]}, 32'hBC);
        chk("c_l3_charisk", {28'h0, o_k}, 32'h1);
`ifdef RX_LANE_ALIGN_STAT_EN
        chk("c_relock_cnt", {16'h0, o_relock}, 32'h1);
        chk("c_offset", {30'h0, o_off}, 32'h3);
`endif

        // CHECK at cnt=2 on lane 1, a lane-0 comma sends it back to HUNT.
        do_reset();
        step(1'b1, C_L1, 4'b0010);
        step(1'b1, C_L1, 4'b0010);
        step(1'b1, C_L0, 4'b0001);
        chk("d_wrong_lane", {31'h0, o_al}, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, C_L1, 4'b0010);
        chk("d_requal_3", {31'h0, o_al}, 32'h0);
        step(1'b1, C_L1, 4'b0010);
        chk("d_requal_4", {31'h0, o_al}, 32'h1);

        // One-cycle byte-align drop while locked.
        step(1'b1, C_L1, 4'b0010);
        step(1'b1, C_L1, 4'b0010);
        chk("e_locked_k", {28'h0, o_k}, 32'h1);
        step(1'b0, C_L1, 4'b0010);
        chk("e_drop_aligned", {31'h0, o_al}, 32'h0);
        chk("e_drop_k", {28'h0, o_k}, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, C_L1, 4'b0010);
        chk("e_requal_3", {31'h0, o_al}, 32'h0);
        step(1'b1, C_L1, 4'b0010);
        chk("e_requal_4", {31'h0, o_al}, 32'h1);

        // Reset mid-CHECK, then a double-hit word that must be ignored.
        do_reset();
        step(1'b1, C_L0, 4'b0001);
        step(1'b1, C_L0, 4'b0001);
        rst = 1'b1;
        step(1'b1, C_L0, 4'b0001);
        rst = 1'b0;
        chk("f_rst_aligned", {31'h0, o_al}, 32'h0);
        chk("f_rst_data", o_data, 32'h0);
        chk("f_rst_k", {28'h0, o_k}, 32'h0);
        step(1'b1, C_L0, 4'b0001);
        step(1'b1, 32'h00BC00BC, 4'b0101);
        chk("f_double_hit", {31'h0, o_al}, 32'h0);
        step(1'b1, C_L0, 4'b0001);
        step(1'b1, C_L0, 4'b0001);
        chk("f_count_3", {31'h0, o_al}, 32'h0);
        step(1'b1, C_L0, 4'b0001);
        chk("f_count_4", {31'h0, o_al}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
